// File: rtl/fnd_scan_if.sv
// fnd_if: digit source to scan driver bundle (BCD digits, decimal points, controls, 7-seg outputs)
interface fnd_if #(parameter int DIGITS = 8);
  logic [4*DIGITS-1:0] bcd_in;
  logic [DIGITS-1:0]   dp_in;
  logic                lz_blank;
  logic                blank_all;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   fnd_row;
  logic                frame_done;
  modport master (output bcd_in, dp_in, lz_blank, blank_all, input seg, fnd_row, frame_done);
  modport slave (input bcd_in, dp_in, lz_blank, blank_all, output seg, fnd_row, frame_done);
endinterface

// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: time-multiplexed 7-seg scan with dead time, leading-zero blanking and per-frame snapshot
module fnd_scan_driver #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input logic clk,
  input logic rst,
  fnd_if.slave bus
);
  localparam int IW = $clog2(DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [6:0] seg_lut [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  logic [PW-1:0]       ph;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] sh_bcd;
  logic [DIGITS-1:0]   sh_dp;
  logic                sh_lz;
  logic [DIGITS-1:0]   lz_mask;
  logic                zero_run;
  logic [3:0]          dig;
  logic                lit;
  logic                last_ph;
  logic                last_idx;
  logic [7:0]          seg_d;
  logic [DIGITS-1:0]   row_d;
  assign last_ph  = ph == PW'(SCAN_DIV - 1);
  assign last_idx = idx == IW'(DIGITS - 1);
  // lz_mask[i] marks digits that are zero along with every higher digit; digit 0 stays visible
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run & (sh_bcd[4*i +: 4] == 4'd0);
      lz_mask[i] = zero_run;
    end
    dig   = sh_bcd[4*idx +: 4];
    lit   = !bus.blank_all && ph >= PW'(BLANK_CYCLES);
    seg_d = lit ? {(sh_lz && lz_mask[idx]) ? 7'd0 : seg_lut[dig], sh_dp[idx]} : 8'd0;
    row_d = lit ? DIGITS'(1) << idx : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      ph             <= '0;
      idx            <= '0;
      sh_bcd         <= '0;
      sh_dp          <= '0;
      sh_lz          <= 1'b0;
      bus.seg        <= '0;
      bus.fnd_row    <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      ph <= last_ph ? '0 : ph + 1'b1;
      if (last_ph) idx <= last_idx ? '0 : idx + 1'b1;
      if (ph == '0 && idx == '0) begin
        sh_bcd <= bus.bcd_in;
        sh_dp  <= bus.dp_in;
        sh_lz  <= bus.lz_blank;
      end
      bus.seg        <= seg_d;
      bus.fnd_row    <= row_d;
      bus.frame_done <= last_ph && last_idx;
    end
  end
endmodule

// File: tb/tb_fnd_scan_driver.sv
// tb_fnd_scan_driver: directed scenarios for the 7-seg scan driver (8 digits, 8-cycle slots, 2 dead cycles)
module tb_fnd_scan_driver;
  localparam int DIGITS = 8, SCAN_DIV = 8, BLANK_CYCLES = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0, errors = 0, t = 0;
  always #5 clk = ~clk;
  fnd_if #(.DIGITS(DIGITS)) bus ();
  fnd_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  // t = edges since reset release; outputs seen after cyc reflect scan position t-1
  task automatic cyc();
    @(posedge clk);
    t++;
    @(negedge clk);
  endtask
  task automatic align();
    while (t % 64 != 0) cyc();
  endtask
  task automatic test_reset();
    logic [7:0] er, es;
    rst = 1'b0;
    bus.bcd_in = '0;
    bus.dp_in = '0;
    bus.lz_blank = 1'b0;
    bus.blank_all = 1'b0;
    repeat (3) begin
      cyc();
      vectors++;
      if ({bus.seg, bus.fnd_row, bus.frame_done} !== 17'd0) begin
        errors++;
        $display("FAIL reset_hold: seg=%b row=%b fd=%b, want all 0", bus.seg, bus.fnd_row, bus.frame_done);
      end
    end
    rst = 1'b1;
    t = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      er = k < 2 ? 8'h00 : 8'h01;
      es = k < 2 ? 8'h00 : 8'b11111100;
      vectors++;
      if (bus.fnd_row !== er || bus.seg !== es || bus.frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_release k=%0d: row=%b seg=%b fd=%b, want row=%b seg=%b fd=0", k, bus.fnd_row, bus.seg, bus.frame_done, er, es);
      end
    end
  endtask
  task automatic test_digits();
    logic [7:0] e [8];
    int n;
    e = '{8'b11111110, 8'b11100000, 8'b10111110, 8'b10110110, 8'b01100110, 8'b11110010, 8'b11011010, 8'b01100000};
    align();
    bus.bcd_in = 32'h12345678;
    bus.dp_in = '0;
    bus.lz_blank = 1'b0;
    for (int d = 0; d < 8; d++) for (int p = 0; p < 8; p++) begin
      cyc();
      if (p == 1) begin
        vectors++;
        if (bus.fnd_row !== 8'h00 || bus.seg !== 8'h00) begin
          errors++;
          $display("FAIL digits_dead d=%0d: row=%b seg=%b, want 0/0", d, bus.fnd_row, bus.seg);
        end
      end
      if (p == 5) begin
        vectors++;
        if (bus.fnd_row !== (8'h01 << d) || bus.seg !== e[d]) begin
          errors++;
          $display("FAIL digits_lit d=%0d: row=%b seg=%b, want row=%b seg=%b", d, bus.fnd_row, bus.seg, 8'h01 << d, e[d]);
        end
      end
      if (p == 7 || (d == 7 && p == 6)) begin
        vectors++;
        if (bus.frame_done !== (d == 7 && p == 7)) begin
          errors++;
          $display("FAIL digits_fd d=%0d p=%0d: fd=%b, want %b", d, p, bus.frame_done, d == 7 && p == 7);
        end
      end
    end
    n = 0;
    repeat (128) begin
      cyc();
      if (bus.frame_done === 1'b1) n++;
    end
    vectors++;
    if (n != 2) begin
      errors++;
      $display("FAIL frame_period: %0d pulses in 128 cycles, want 2", n);
    end
  endtask
  task automatic test_lz_blank();
    logic [31:0] bi [3];
    logic [7:0]  di [3];
    logic [7:0]  e [3][8];
    bi = '{32'h00000305, 32'h0, 32'h0};
    di = '{8'h00, 8'h00, 8'h20};
    e[0] = '{8'b10110110, 8'b11111100, 8'b11110010, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    e[1] = '{8'b11111100, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    e[2] = '{8'b11111100, 8'h00, 8'h00, 8'h00, 8'h00, 8'b00000001, 8'h00, 8'h00};
    for (int f = 0; f < 3; f++) begin
      align();
      bus.bcd_in = bi[f];
      bus.dp_in = di[f];
      bus.lz_blank = 1'b1;
      for (int d = 0; d < 8; d++) for (int p = 0; p < 8; p++) begin
        cyc();
        if (p == 5) begin
          vectors++;
          if (bus.fnd_row !== (8'h01 << d) || bus.seg !== e[f][d]) begin
            errors++;
            $display("FAIL lz_blank f=%0d d=%0d: row=%b seg=%b, want row=%b seg=%b", f, d, bus.fnd_row, bus.seg, 8'h01 << d, e[f][d]);
          end
        end
      end
    end
    bus.lz_blank = 1'b0;
    bus.dp_in = '0;
  endtask
  task automatic test_snapshot();
    align();
    bus.bcd_in = 32'h11111111;
    for (int f = 0; f < 2; f++) for (int d = 0; d < 8; d++) for (int p = 0; p < 8; p++) begin
      if (f == 0 && d == 3 && p == 0) bus.bcd_in = 32'h22222222;
      cyc();
      if (p == 5 && (f == 1 || d >= 3)) begin
        vectors++;
        if (bus.seg !== (f == 0 ? 8'b01100000 : 8'b11011010)) begin
          errors++;
          $display("FAIL snapshot f=%0d d=%0d: seg=%b, want %b", f, d, bus.seg, f == 0 ? 8'b01100000 : 8'b11011010);
        end
      end
    end
  endtask
  task automatic test_blank_all();
    logic [7:0] er, es;
    align();
    bus.bcd_in = 32'h12345678;
    for (int d = 0; d < 8; d++) for (int p = 0; p < 8; p++) begin
      if (d == 2 && p == 0) bus.blank_all = 1'b1;
      if (d == 5 && p == 4) bus.blank_all = 1'b0;
      cyc();
      if ((p == 5 && d >= 1 && d <= 4) || (d == 5 && (p == 3 || p == 4))) begin
        er = (d == 1) ? 8'h02 : (d == 5 && p == 4) ? 8'h20 : 8'h00;
        es = (d == 1) ? 8'b11100000 : (d == 5 && p == 4) ? 8'b11110010 : 8'h00;
        vectors++;
        if (bus.fnd_row !== er || bus.seg !== es) begin
          errors++;
          $display("FAIL blank_all d=%0d p=%0d: row=%b seg=%b, want row=%b seg=%b", d, p, bus.fnd_row, bus.seg, er, es);
        end
      end
      if (d == 7 && p >= 6) begin
        vectors++;
        if (bus.frame_done !== (p == 7)) begin
          errors++;
          $display("FAIL blank_all_fd p=%0d: fd=%b, want %b", p, bus.frame_done, p == 7);
        end
      end
    end
  endtask
  task automatic test_mid_reset();
    logic [7:0] er, es;
    align();
    bus.bcd_in = 32'h11111111;
    repeat (51) cyc();
    vectors++;
    if (bus.fnd_row !== 8'h40 || bus.seg !== 8'b01100000) begin
      errors++;
      $display("FAIL pre_reset: row=%b seg=%b, want row=01000000 seg=01100000", bus.fnd_row, bus.seg);
    end
    rst = 1'b0;
    bus.bcd_in = 32'h99999999;
    cyc();
    vectors++;
    if ({bus.seg, bus.fnd_row, bus.frame_done} !== 17'd0) begin
      errors++;
      $display("FAIL mid_reset: seg=%b row=%b fd=%b, want all 0", bus.seg, bus.fnd_row, bus.frame_done);
    end
    rst = 1'b1;
    t = 0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      er = (k % 8 < 2) ? 8'h00 : (k < 8 ? 8'h01 : 8'h02);
      es = (k % 8 < 2) ? 8'h00 : 8'b11110110;
      vectors++;
      if (bus.fnd_row !== er || bus.seg !== es) begin
        errors++;
        $display("FAIL restart k=%0d: row=%b seg=%b, want row=%b seg=%b", k, bus.fnd_row, bus.seg, er, es);
      end
    end
    repeat (47) cyc();
    vectors++;
    if (bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL restart_fd_early: fd=%b, want 0", bus.frame_done);
    end
    cyc();
    vectors++;
    if (bus.frame_done !== 1'b1) begin
      errors++;
      $display("FAIL restart_fd: fd=%b, want 1", bus.frame_done);
    end
  endtask
  initial begin
    test_reset();
    test_digits();
    test_lz_blank();
    test_snapshot();
    test_blank_all();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
